// File: rtl/regfile_wrport_arb_if.sv
// Write-port front-end bundle: four requesters, the registered
// register-file write port and the pending-write check port.
interface regfile_wrport_arb_if #(
  parameter int DW = 72,
  parameter int AW = 8
);
  logic          req0_valid;
  logic          req1_valid;
  logic          req2_valid;
  logic          req3_valid;
  logic [AW-1:0] req0_addr;
  logic [AW-1:0] req1_addr;
  logic [AW-1:0] req2_addr;
  logic [AW-1:0] req3_addr;
  logic [DW-1:0] req0_data;
  logic [DW-1:0] req1_data;
  logic [DW-1:0] req2_data;
  logic [DW-1:0] req3_data;
  logic          req0_ready;
  logic          req1_ready;
  logic          req2_ready;
  logic          req3_ready;
  logic          wren;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] din;
  logic [AW-1:0] chk_addr;
  logic          chk_hit;

  modport master (
    output req0_valid, req1_valid, req2_valid, req3_valid,
    output req0_addr, req1_addr, req2_addr, req3_addr,
    output req0_data, req1_data, req2_data, req3_data,
    output chk_addr,
    input  req0_ready, req1_ready, req2_ready, req3_ready,
    input  wren, wraddr, din, chk_hit
  );

  modport slave (
    input  req0_valid, req1_valid, req2_valid, req3_valid,
    input  req0_addr, req1_addr, req2_addr, req3_addr,
    input  req0_data, req1_data, req2_data, req3_data,
    input  chk_addr,
    output req0_ready, req1_ready, req2_ready, req3_ready,
    output wren, wraddr, din, chk_hit
  );
endinterface

// File: rtl/regfile_wrport_arb.sv
// Four 2-deep write buffers drained round-robin onto the
// registered register-file write port, with a RAW hazard check.
module regfile_wrport_arb #(
  parameter int DW = 72,
  parameter int AW = 8
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wrport_arb_if.slave bus
);

  logic [3:0]    in_valid;
  logic [AW-1:0] in_addr [4];
  logic [DW-1:0] in_data [4];
  logic [3:0]    ready;
  logic [3:0]    push;
  logic [3:0]    pop;

  logic [1:0]    cnt_q [4];
  logic [1:0]    cnt_d [4];
  logic [AW-1:0] ba_q [4][2];
  logic [AW-1:0] ba_d [4][2];
  logic [DW-1:0] bd_q [4][2];
  logic [DW-1:0] bd_d [4][2];
  logic [1:0]    ptr_q, ptr_d;
  logic          wren_q, wren_d;
  logic [AW-1:0] wraddr_q, wraddr_d;
  logic [DW-1:0] din_q, din_d;

  logic          gnt_vld;
  logic [1:0]    gnt;
  logic [1:0]    idx;
  logic          slot;
  logic          hit;

  assign in_valid = {bus.req3_valid, bus.req2_valid,
                     bus.req1_valid, bus.req0_valid};
  assign in_addr[0] = bus.req0_addr;
  assign in_addr[1] = bus.req1_addr;
  assign in_addr[2] = bus.req2_addr;
  assign in_addr[3] = bus.req3_addr;
  assign in_data[0] = bus.req0_data;
  assign in_data[1] = bus.req1_data;
  assign in_data[2] = bus.req2_data;
  assign in_data[3] = bus.req3_data;

  // Ready comes from registered count only, so a pop never opens it early.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      ready[n] = (cnt_q[n] < 2'd2) && !rst;
      push[n]  = in_valid[n] && ready[n];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = ptr_q;
    idx     = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_vld && cnt_q[idx] != 2'd0) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    wren_d   = 1'b0;
    wraddr_d = wraddr_q;
    din_d    = din_q;
    cnt_d    = cnt_q;
    ba_d     = ba_q;
    bd_d     = bd_q;
    pop      = 4'b0;
    slot     = 1'b0;
    if (gnt_vld) begin
      wren_d   = 1'b1;
      wraddr_d = ba_q[gnt][0];
      din_d    = bd_q[gnt][0];
      ptr_d    = gnt + 2'd1;
    end
    for (int n = 0; n < 4; n++) begin
      pop[n] = gnt_vld && (gnt == 2'(n));
      if (pop[n]) begin
        ba_d[n][0] = ba_q[n][1];
        bd_d[n][0] = bd_q[n][1];
      end
      // Tail slot is 1 only when one entry stays resident.
      slot = !pop[n] && (cnt_q[n] == 2'd1);
      if (push[n]) begin
        ba_d[n][slot] = in_addr[n];
        bd_d[n][slot] = in_data[n];
      end
      cnt_d[n] = cnt_q[n] + {1'b0, push[n]} - {1'b0, pop[n]};
    end
  end

  always_comb begin
    hit = wren_q && (wraddr_q == bus.chk_addr);
    for (int n = 0; n < 4; n++) begin
      if (cnt_q[n] != 2'd0 && ba_q[n][0] == bus.chk_addr) hit = 1'b1;
      if (cnt_q[n] == 2'd2 && ba_q[n][1] == bus.chk_addr) hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) cnt_q[n] <= 2'd0;
      ptr_q    <= 2'd0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      din_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      din_q    <= din_d;
    end
  end

  always_ff @(posedge clk) begin
    ba_q <= ba_d;
    bd_q <= bd_d;
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.req2_ready = ready[2];
  assign bus.req3_ready = ready[3];
  assign bus.wren       = wren_q;
  assign bus.wraddr     = wraddr_q;
  assign bus.din        = din_q;
  assign bus.chk_hit    = hit && !rst;

endmodule

// File: tb/tb_regfile_wrport_arb.sv
// Randomized and directed bench for regfile_wrport_arb against a
// queue-based reference model of the buffers and arbiter.
module tb_regfile_wrport_arb;
  localparam int DW = 72;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wrport_arb_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wrport_arb #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic          v [4];
  logic [AW-1:0] a [4];
  logic [DW-1:0] d [4];
  logic [AW-1:0] chk;
  logic [3:0]    rdy;

  assign bus.req0_valid = v[0];
  assign bus.req1_valid = v[1];
  assign bus.req2_valid = v[2];
  assign bus.req3_valid = v[3];
  assign bus.req0_addr  = a[0];
  assign bus.req1_addr  = a[1];
  assign bus.req2_addr  = a[2];
  assign bus.req3_addr  = a[3];
  assign bus.req0_data  = d[0];
  assign bus.req1_data  = d[1];
  assign bus.req2_data  = d[2];
  assign bus.req3_data  = d[3];
  assign bus.chk_addr   = chk;
  assign rdy = {bus.req3_ready, bus.req2_ready,
                bus.req1_ready, bus.req0_ready};

  logic [AW-1:0] qa [4][$];
  logic [DW-1:0] qd [4][$];
  int            mptr;
  logic          mwren;
  logic [AW-1:0] mwa;
  logic [DW-1:0] mdin;
  bit            acc [4];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(string tag, logic [DW-1:0] obs,
                          logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int g;
    int id;
    g = -1;
    for (int n = 0; n < 4; n++) acc[n] = 1'b0;
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        qa[n].delete();
        qd[n].delete();
      end
      mptr = 0; mwren = 1'b0; mwa = '0; mdin = '0;
    end else begin
      for (int n = 0; n < 4; n++)
        acc[n] = v[n] && (qa[n].size() < 2);
      for (int k = 0; k < 4; k++) begin
        id = (mptr + k) % 4;
        if (g < 0 && qa[id].size() > 0) g = id;
      end
      if (g >= 0) begin
        mwren = 1'b1;
        mwa   = qa[g].pop_front();
        mdin  = qd[g].pop_front();
        mptr  = (g + 1) % 4;
      end else begin
        mwren = 1'b0;
      end
      for (int n = 0; n < 4; n++)
        if (acc[n]) begin
          qa[n].push_back(a[n]);
          qd[n].push_back(d[n]);
        end
    end
  endtask

  function automatic logic model_hit();
    logic h;
    if (rst) return 1'b0;
    h = mwren && (mwa == chk);
    for (int n = 0; n < 4; n++)
      foreach (qa[n][i]) if (qa[n][i] == chk) h = 1'b1;
    return h;
  endfunction

  task automatic check_all();
    for (int n = 0; n < 4; n++)
      check_eq($sformatf("ready%0d", n), DW'(rdy[n]),
               DW'(!rst && qa[n].size() < 2));
    check_eq("wren", DW'(bus.wren), DW'(mwren));
    check_eq("wraddr", DW'(bus.wraddr), DW'(mwa));
    check_eq("din", bus.din, mdin);
    check_eq("chk_hit", DW'(bus.chk_hit), DW'(model_hit()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_in();
    for (int n = 0; n < 4; n++) begin
      v[n] = 1'b0; a[n] = '0; d[n] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [AW-1:0] commits [$];
  int            kk [4];
  bit            busy;

  initial begin
    rst = 1'b1;
    chk = '0;
    clear_in();
    mptr = 0; mwren = 1'b0; mwa = '0; mdin = '0;

    do_reset();
    check_eq("idle_ready", DW'(rdy), DW'(4'hf));
    check_eq("idle_wren", DW'(bus.wren), '0);
    check_eq("idle_hit", DW'(bus.chk_hit), '0);

    v[0] = 1'b1; a[0] = 8'h12; d[0] = 72'h0A_5A5A5A5A_5A5A5A5A;
    tick();
    clear_in();
    check_eq("single_lat1", DW'(bus.wren), '0);
    tick();
    check_eq("single_wren", DW'(bus.wren), DW'(1'b1));
    check_eq("single_addr", DW'(bus.wraddr), DW'(8'h12));
    check_eq("single_din", bus.din, 72'h0A_5A5A5A5A_5A5A5A5A);
    tick();
    check_eq("single_once", DW'(bus.wren), '0);

    do_reset();
    for (int n = 0; n < 4; n++) kk[n] = 0;
    commits.delete();
    for (int cyc = 0; cyc < 60 && commits.size() < 12; cyc++) begin
      for (int n = 0; n < 4; n++) begin
        v[n] = kk[n] < 3;
        a[n] = AW'(8'h10 + n * 4 + kk[n]);
        d[n] = {8'($urandom), $urandom, $urandom};
      end
      tick();
      for (int n = 0; n < 4; n++) if (acc[n]) kk[n]++;
      if (bus.wren) commits.push_back(bus.wraddr);
    end
    clear_in();
    check_eq("rr_count", DW'(commits.size()), DW'(12));
    for (int i = 0; i < 12 && i < commits.size(); i++)
      check_eq($sformatf("rr_order%0d", i), DW'(commits[i]),
               DW'(8'h10 + (i % 4) * 4 + i / 4));

    do_reset();
    v[2] = 1'b1; a[2] = 8'h20; d[2] = 72'h2;
    tick();
    clear_in();
    tick();
    check_eq("fair_first", DW'(bus.wraddr), DW'(8'h20));
    v[1] = 1'b1; a[1] = 8'h21; d[1] = 72'h1;
    v[3] = 1'b1; a[3] = 8'h23; d[3] = 72'h3;
    tick();
    clear_in();
    tick();
    check_eq("fair_req3", DW'(bus.wraddr), DW'(8'h23));
    tick();
    check_eq("fair_req1", DW'(bus.wraddr), DW'(8'h21));
    tick();

    chk = 8'h40;
    v[1] = 1'b1; a[1] = 8'h40; d[1] = 72'h40;
    tick();
    clear_in();
    check_eq("haz_buf", DW'(bus.chk_hit), DW'(1'b1));
    tick();
    check_eq("haz_out", DW'(bus.chk_hit), DW'(1'b1));
    check_eq("haz_out_addr", DW'(bus.wraddr), DW'(8'h40));
    tick();
    check_eq("haz_clear", DW'(bus.chk_hit), '0);
    chk = 8'h41;
    v[1] = 1'b1; a[1] = 8'h40; d[1] = 72'h41;
    tick();
    clear_in();
    check_eq("haz_miss", DW'(bus.chk_hit), '0);
    tick();
    check_eq("haz_miss_out", DW'(bus.chk_hit), '0);
    tick();

    do_reset();
    v[0] = 1'b1; a[0] = 8'h50;
    v[1] = 1'b1; a[1] = 8'h60;
    tick();
    v[1] = 1'b0; a[0] = 8'h51;
    tick();
    a[0] = 8'h52;
    tick();
    clear_in();
    check_eq("mid_pre_wren", DW'(bus.wren), DW'(1'b1));
    check_eq("mid_pre_full", DW'(rdy[0]), '0);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_wren", DW'(bus.wren), '0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mid_no_write", DW'(bus.wren), '0);
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom % 60) == 0;
      for (int n = 0; n < 4; n++) begin
        v[n] = ($urandom % 3) != 0;
        a[n] = AW'($urandom % 16);
        d[n] = {8'($urandom), $urandom, $urandom};
      end
      chk = AW'($urandom % 16);
      tick();
    end
    rst = 1'b0;
    clear_in();
    busy = 1'b1;
    for (int cyc = 0; cyc < 20 && busy; cyc++) begin
      tick();
      busy = mwren;
      for (int n = 0; n < 4; n++) if (qa[n].size() > 0) busy = 1'b1;
    end
    check_eq("drain_idle", DW'(bus.wren), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wrport_arb.md
Name: regfile_wrport_arb

Overview:
- Front end that feeds the single write port (din/wraddr/wren) of the 1-write/4-read 72-bit register file from four independent write requesters.
- Each requester has a valid/ready handshake and a 2-entry buffer. A round-robin arbiter drains one entry per cycle onto the registered write port.
- A pending-write check port lets read-side logic detect read-after-write hazards against writes accepted but not yet committed.

Parameters:
- DW, 72, write data width (matches register file word).
- AW, 8, write address width.
- Requester count is fixed at 4. Buffer depth is fixed at 2 entries per requester.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- req0_valid..req3_valid  input  1 each  requester n has a write to offer.
- req0_addr..req3_addr  input  AW each  target register address.
- req0_data..req3_data  input  DW each  write data.
- req0_ready..req3_ready  output  1 each  buffer n can accept this cycle.
- wren  output  1  write enable to register file (registered).
- wraddr  output  AW  write address to register file (registered).
- din  output  DW  write data to register file (registered).
- chk_addr  input  AW  address to test for pending writes.
- chk_hit  output  1  chk_addr matches any valid buffered entry or the in-flight output write.

Behaviour:
- Reset (rst high at posedge):
  - all buffer counts cleared; round-robin pointer = 0.
  - wren = 0, wraddr = 0, din = 0.
  - reqN_ready = 0 while rst is high; chk_hit = 0 while rst is high.
- Ready:
  - reqN_ready = (countN < 2) and not rst.
  - It depends only on registered count. There is no combinational path from a pop or from reqN_valid.
  - A full buffer that is popped in the current cycle still shows ready = 0 for that cycle.
- Accept:
  - A push happens on a posedge where reqN_valid & reqN_ready.
  - The entry is written at the tail; countN increments unless a pop occurs in the same cycle.
  - Push and pop together on a 1-entry buffer keep count at 1 and order is preserved (FIFO).
- Arbitration (each cycle, combinational on registered state):
  - Candidates are the buffers with count > 0.
  - The grant goes to the first candidate at or after ptr, scanning ptr, ptr+1, ... mod 4.
  - The granted buffer's head is popped at the posedge.
  - ptr <= (granted index + 1) mod 4. If there is no candidate, ptr is unchanged.
- Output register:
  - On a posedge with a grant: wren <= 1, wraddr <= head addr, din <= head data.
  - Without a grant: wren <= 0, and wraddr/din hold their previous values.
- Latency: a request accepted at edge E gives wren high in the cycle after edge E+1 (2 cycles minimum), provided it wins arbitration at E+1.
- Throughput: one write per cycle sustained. With all four buffers busy, each requester is guaranteed 1 grant in every 4 cycles.
- Ordering:
  - Per requester: strict FIFO.
  - Across requesters: grant order. There is no address merging or coalescing; two writes to the same address both commit.
- chk_hit:
  - Combinational OR of chk_addr == addr over all valid buffer entries (8 slots), plus (wren & chk_addr == wraddr).
  - The output register is included because the register file commits it at the next edge.
- Reset mid-operation: buffered entries are discarded without being written, and wren drops at that same edge.

Test Plan:
- Reset, then idle → ready0..3 = 1, wren = 0, chk_hit = 0 for chk_addr = 0x00.
- Single write: req0 valid for 1 cycle with addr 0x12, data 0x0A_5A5A5A5A_5A5A5A5A → wren = 1 for exactly 1 cycle, 2 cycles after the accepting edge, with wraddr = 0x12 and matching din.
- All four requesters valid with 3 writes each (addr 0x10+n*4+k); req pushes stall when ready = 0 → grant order 0,1,2,3,0,1,2,3,... At each requester, ready drops to 0 after 2 accepts and returns to 1 once its count falls below 2. All 12 writes commit in per-requester order.
- Pointer fairness: req2 alone writes 0x20, then req1 and req3 arrive simultaneously → req3 granted before req1 (ptr = 3 after the grant to 2).
- Hazard: req1 accepts addr 0x40 → chk_hit = 1 for chk_addr = 0x40 from the cycle after acceptance through the cycle wren = 1 with wraddr = 0x40, then 0. chk_hit stays 0 throughout for chk_addr = 0x41.
- Reset with 2 entries buffered in req0 and wren = 1 → at the reset edge wren = 0 and counts = 0. No further writes appear after rst is released.
